// File: rtl/rect_stream_processor.sv
// Rectifier stage: bypass / half / full / neg-half on a valid/ready stream.
// Side outputs: windowed average, peak hold and zero-crossing count.
module rect_stream_processor #(
  parameter int DATA_W   = 8,
  parameter int WIN_LOG2 = 3,
  parameter int ZC_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              avg_valid,
  output logic [DATA_W-1:0] avg_data,
  output logic [DATA_W-1:0] peak_data,
  input  logic              peak_clr,
  output logic [ZC_W-1:0]   zc_count
);

  localparam int ACC_W = DATA_W + WIN_LOG2;

  localparam logic [DATA_W-1:0] MAXP =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MINN =
    {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state;
  logic                accept;
  logic                xfer;
  logic                neg;
  logic [DATA_W-1:0]   mag;
  logic [DATA_W-1:0]   rect;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    sum;
  logic [WIN_LOG2-1:0] cnt;
  logic                prev_sign;
  logic                first;

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign sum       = acc + {{WIN_LOG2{1'b0}}, out_data};

  // Rectify the incoming sample; most-negative input saturates to MAXP.
  always_comb begin
    neg  = in_data[DATA_W-1];
    mag  = in_data;
    rect = in_data;
    if (neg)
      mag = (in_data == MINN) ? MAXP : -in_data;
    unique case (mode)
      2'b00: rect = in_data;
      2'b01: rect = neg ? '0 : in_data;
      2'b10: rect = mag;
      2'b11: rect = neg ? mag : '0;
    endcase
  end

  // EMPTY/FULL output register; new sample may replace one leaving.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
    end else begin
      unique case (state)
        EMPTY: if (accept) state <= FULL;
        FULL:  if (xfer && !accept) state <= EMPTY;
      endcase
      if (accept)
        out_data <= rect;
    end
  end

  // Window accumulator; last transfer of a window is folded into the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      avg_valid <= 1'b0;
      avg_data  <= '0;
    end else begin
      avg_valid <= 1'b0;
      if (xfer) begin
        if (cnt == '1) begin
          avg_data  <= sum[ACC_W-1:WIN_LOG2];
          avg_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Peak hold; a coincident transfer wins over a clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      peak_data <= '0;
    end else if (xfer) begin
      if (peak_clr || out_data > peak_data)
        peak_data <= out_data;
    end else if (peak_clr) begin
      peak_data <= '0;
    end
  end

  // Count sign changes between consecutive accepted samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zc_count  <= '0;
      prev_sign <= 1'b0;
      first     <= 1'b1;
    end else if (accept) begin
      if (!first && (in_data[DATA_W-1] != prev_sign))
        zc_count <= zc_count + 1'b1;
      prev_sign <= in_data[DATA_W-1];
      first     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rect_stream_processor.sv
// Scoreboard bench for rect_stream_processor.
// Directed vectors; monitors pop expected out/avg values on transfers.
module tb_rect_stream_processor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        avg_valid;
  logic [7:0]  avg_data;
  logic [7:0]  peak_data;
  logic        peak_clr = 1'b0;
  logic [15:0] zc_count;

  int checks = 0;
  int errors = 0;
  int avg_pulses = 0;

  logic [7:0] sb[$];
  logic [7:0] avq[$];

  rect_stream_processor #(
    .DATA_W(8), .WIN_LOG2(3), .ZC_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .avg_valid(avg_valid), .avg_data(avg_data),
    .peak_data(peak_data), .peak_clr(peak_clr),
    .zc_count(zc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: every transfer pops the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_data: got %0h expected none", out_data);
      end else begin
        chk("out_data", {24'h0, out_data}, {24'h0, sb.pop_front()});
      end
    end
  end

  // Average monitor: every pulse pops the average queue.
  always @(negedge clk) begin
    if (rst_n && avg_valid) begin
      avg_pulses++;
      if (avq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL avg_data: got %0h expected none", avg_data);
      end else begin
        chk("avg_data", {24'h0, avg_data}, {24'h0, avq.pop_front()});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m,
                      input logic [7:0] d,
                      input logic [7:0] exp);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    mode     = m;
    in_data  = d;
    in_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (ok) begin
      sb.push_back(exp);
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got none expected %0h", d);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    peak_clr = 1'b0;
    out_ready = 1'b1;
    sb.delete();
    avq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_out_valid", {31'h0, out_valid}, 0);
    chk("rst_out_data", {24'h0, out_data}, 0);
    chk("rst_avg_valid", {31'h0, avg_valid}, 0);
    chk("rst_avg_data", {24'h0, avg_data}, 0);
    chk("rst_peak", {24'h0, peak_data}, 0);
    chk("rst_zc", {16'h0, zc_count}, 0);
    chk("rst_in_ready", {31'h0, in_ready}, 1);

    // 55,00,00,25,7F,7F,25,7F -> 540 >> 3 = 0x43
    avq.push_back(8'h43);
    send(2'b01, 8'h55, 8'h55);
    send(2'b01, 8'hDB, 8'h00);
    send(2'b01, 8'h00, 8'h00);
    idle(2);
    chk("zc_half", {16'h0, zc_count}, 2);

    send(2'b10, 8'hDB, 8'h25);
    send(2'b10, 8'h80, 8'h7F);
    send(2'b10, 8'h7F, 8'h7F);
    send(2'b11, 8'hDB, 8'h25);
    send(2'b11, 8'h80, 8'h7F);
    send(2'b11, 8'h7F, 8'h00);
    send(2'b00, 8'hDB, 8'hDB);
    send(2'b00, 8'h80, 8'h80);
    send(2'b00, 8'h7F, 8'h7F);
    idle(3);
    chk("sb_empty_modes", sb.size(), 0);
    chk("avq_empty_modes", avq.size(), 0);

    // Back-pressure
    do_reset();
    send(2'b01, 8'h40, 8'h40);
    out_ready = 1'b0;
    mode      = 2'b01;
    in_data   = 8'h30;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'h0, in_ready}, 0);
      chk("bp_hold_data", {24'h0, out_data}, 8'h40);
      chk("bp_hold_valid", {31'h0, out_valid}, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(2'b01, 8'h30, 8'h30);
    idle(3);
    chk("sb_empty_bp", sb.size(), 0);

    // Average windows, with an idle gap inside the second window
    do_reset();
    avq.push_back(8'h10);
    avq.push_back(8'h03);
    for (int i = 0; i < 8; i++)
      send(2'b10, 8'hF0, 8'h10);
    for (int i = 0; i < 8; i++) begin
      send(2'b01, 8'(i), 8'(i));
      if (i == 3) idle(4);
    end
    idle(3);
    chk("avq_empty_avg", avq.size(), 0);

    // Peak hold (peak currently 0x10 from the first window)
    send(2'b10, 8'h20, 8'h20);
    idle(1);
    chk("peak_20", {24'h0, peak_data}, 8'h20);
    send(2'b10, 8'hA0, 8'h60);
    idle(1);
    chk("peak_60", {24'h0, peak_data}, 8'h60);
    send(2'b10, 8'h10, 8'h10);
    idle(1);
    chk("peak_hold", {24'h0, peak_data}, 8'h60);
    send(2'b10, 8'h10, 8'h10);
    peak_clr = 1'b1;
    idle(1);
    peak_clr = 1'b0;
    chk("peak_clr_xfer", {24'h0, peak_data}, 8'h10);
    peak_clr = 1'b1;
    idle(1);
    peak_clr = 1'b0;
    chk("peak_clr", {24'h0, peak_data}, 0);

    // Mid-stream reset: 5 samples in the window, one held
    send(2'b00, 8'h08, 8'h08);
    idle(1);
    out_ready = 1'b0;
    send(2'b00, 8'h09, 8'h09);
    idle(1);
    chk("pre_rst_valid", {31'h0, out_valid}, 1);
    sb.delete();
    avq.delete();
    rst_n = 1'b0;
    idle(1);
    chk("mid_rst_valid", {31'h0, out_valid}, 0);
    chk("mid_rst_data", {24'h0, out_data}, 0);
    chk("mid_rst_avg", {24'h0, avg_data}, 0);
    chk("mid_rst_peak", {24'h0, peak_data}, 0);
    chk("mid_rst_zc", {16'h0, zc_count}, 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    avg_pulses = 0;
    // 0x78 + 7*0x08 = 176 >> 3 = 0x16
    avq.push_back(8'h16);
    send(2'b10, 8'h88, 8'h78);
    for (int i = 0; i < 7; i++)
      send(2'b00, 8'h08, 8'h08);
    idle(3);
    chk("post_rst_pulses", avg_pulses, 1);
    chk("post_rst_zc", {16'h0, zc_count}, 1);
    chk("sb_empty_end", sb.size(), 0);
    chk("avq_empty_end", avq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
